// File: rtl/graph_adj_responder.sv
// Next-node fetch responder: stores the graph (offset table, edge list, special nodes)
// and streams header or successor beats. Optional macro ADJ_PREFETCH_EN removes the LOOKUP cycle.
module graph_adj_responder #(
    parameter int unsigned PARAM_NODE_IDX_WIDTH  = 10,
    parameter int unsigned PARAM_COUNTER_WIDTH   = 5,
    parameter int unsigned PARAM_EDGE_ADDR_WIDTH = 12,
    parameter int unsigned PARAM_NUM_NODES       = 1024
) (
    input  logic                                                 clk_i,
    input  logic                                                 rst_i,
    input  logic                                                 load_en_i,
    input  logic [1:0]                                           load_sel_i,
    input  logic [PARAM_EDGE_ADDR_WIDTH-1:0]                     load_addr_i,
    input  logic [PARAM_EDGE_ADDR_WIDTH+PARAM_COUNTER_WIDTH-1:0] load_data_i,
    output logic                                                 load_err_o,
    input  logic                                                 part_sel_i,
    input  logic                                                 hdr_req_i,
    input  logic                                                 rd_req_i,
    input  logic [PARAM_NODE_IDX_WIDTH-1:0]                      node_idx_i,
    output logic                                                 req_ready_o,
    output logic                                                 edge_valid_o,
    input  logic                                                 edge_ready_i,
    output logic [PARAM_NODE_IDX_WIDTH-1:0]                      next_node_idx_o,
    output logic [PARAM_COUNTER_WIDTH-1:0]                       next_node_counter_o
);

    localparam int unsigned NIW        = PARAM_NODE_IDX_WIDTH;
    localparam int unsigned CW         = PARAM_COUNTER_WIDTH;
    localparam int unsigned EAW        = PARAM_EDGE_ADDR_WIDTH;
    localparam int unsigned ENT_W      = EAW + CW;
    localparam int unsigned TBL_AW     = (PARAM_NUM_NODES > 1) ? $clog2(PARAM_NUM_NODES) : 1;
    localparam int unsigned EDGE_DEPTH = 2 ** EAW;

    typedef enum logic [1:0] {IDLE, HDR, LOOKUP, STREAM} state_e;

    state_e state_q, state_d;

    logic [ENT_W-1:0] offset_mem [PARAM_NUM_NODES];
    logic [NIW-1:0]   edge_mem   [EDGE_DEPTH];
    logic [NIW-1:0]   special_q  [4];

    logic           valid_q, valid_d;
    logic [NIW-1:0] idx_q, idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [EAW-1:0] ptr_q, ptr_d;
    logic           part_q, part_d;
    logic [1:0]     hpos_q, hpos_d;
    logic           load_err_q, load_err_d;
    logic           req_ready_q, req_ready_d;
`ifndef ADJ_PREFETCH_EN
    logic [NIW-1:0] node_q, node_d;
`endif

    logic           fire_c;
    logic           load_ok_c;
    logic           first_c;
    logic [NIW-1:0] lk_node_c;
    logic [ENT_W-1:0] lk_ent_c;
    logic [EAW-1:0] lk_base_c;
    logic [CW-1:0]  lk_deg_c;
    logic [EAW-1:0] nxt_ptr_c;

    assign fire_c    = valid_q & edge_ready_i;
    assign load_ok_c = load_en_i & (state_q == IDLE);
    assign nxt_ptr_c = ptr_q + EAW'(1);

    // Offset table lookup source: live request index when prefetching, captured index otherwise
    always_comb begin
`ifdef ADJ_PREFETCH_EN
        lk_node_c = node_idx_i;
        first_c   = (state_q == IDLE) & ~hdr_req_i & rd_req_i;
`else
        lk_node_c = node_q;
        first_c   = (state_q == LOOKUP);
`endif
        lk_ent_c = '0;
        if (32'(lk_node_c) < PARAM_NUM_NODES) begin
            lk_ent_c = offset_mem[TBL_AW'(lk_node_c)];
        end
        lk_base_c = lk_ent_c[ENT_W-1:CW];
        lk_deg_c  = lk_ent_c[CW-1:0];
    end

    // Graph storage writes; contents survive reset
    always_ff @(posedge clk_i) begin
        if (load_ok_c && load_sel_i == 2'd0 && 32'(load_addr_i) < PARAM_NUM_NODES) begin
            offset_mem[TBL_AW'(load_addr_i)] <= load_data_i;
        end
        if (load_ok_c && load_sel_i == 2'd1) begin
            edge_mem[load_addr_i] <= load_data_i[NIW-1:0];
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hdr_req_i) begin
                    state_d = HDR;
                end else if (rd_req_i) begin
`ifdef ADJ_PREFETCH_EN
                    state_d = STREAM;
`else
                    state_d = LOOKUP;
`endif
                end
            end
            HDR: begin
                if (fire_c && cnt_q == CW'(1)) state_d = IDLE;
            end
            LOOKUP: state_d = STREAM;
            STREAM: begin
                if (fire_c && cnt_q <= CW'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        valid_d     = valid_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        part_d      = part_q;
        hpos_d      = hpos_q;
        load_err_d  = load_err_q | (load_en_i & (state_q != IDLE));
        req_ready_d = (state_d == IDLE);
`ifndef ADJ_PREFETCH_EN
        node_d      = node_q;
`endif
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (hdr_req_i) begin
                    part_d  = part_sel_i;
                    hpos_d  = 2'd0;
                    valid_d = 1'b1;
                    idx_d   = special_q[0];
                    cnt_d   = part_sel_i ? CW'(4) : CW'(2);
                end else if (rd_req_i) begin
`ifndef ADJ_PREFETCH_EN
                    node_d = node_idx_i;
`endif
                end
            end
            HDR: begin
                if (fire_c) begin
                    if (cnt_q == CW'(1)) begin
                        valid_d = 1'b0;
                    end else begin
                        hpos_d = part_q ? hpos_q + 2'd1 : 2'd3;
                        idx_d  = special_q[hpos_d];
                        cnt_d  = cnt_q - CW'(1);
                    end
                end
            end
            STREAM: begin
                if (fire_c) begin
                    if (cnt_q <= CW'(1)) begin
                        valid_d = 1'b0;
                    end else begin
                        ptr_d = nxt_ptr_c;
                        idx_d = edge_mem[nxt_ptr_c];
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: ;
        endcase
        // First successor beat; a zero-degree node yields one (0,0) beat
        if (first_c) begin
            valid_d = 1'b1;
            ptr_d   = lk_base_c;
            if (lk_deg_c == '0) begin
                idx_d = '0;
                cnt_d = '0;
            end else begin
                idx_d = edge_mem[lk_base_c];
                cnt_d = lk_deg_c;
            end
        end
    end

    // Registered outputs, datapath and special-node registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            part_q      <= 1'b0;
            hpos_q      <= 2'd0;
            load_err_q  <= 1'b0;
            req_ready_q <= 1'b1;
`ifndef ADJ_PREFETCH_EN
            node_q      <= '0;
`endif
            for (int i = 0; i < 4; i++) special_q[i] <= '0;
        end else begin
            valid_q     <= valid_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            part_q      <= part_d;
            hpos_q      <= hpos_d;
            load_err_q  <= load_err_d;
            req_ready_q <= req_ready_d;
`ifndef ADJ_PREFETCH_EN
            node_q      <= node_d;
`endif
            if (load_ok_c && load_sel_i == 2'd2 && load_addr_i < EAW'(4)) begin
                special_q[load_addr_i[1:0]] <= load_data_i[NIW-1:0];
            end
        end
    end

    assign edge_valid_o        = valid_q;
    assign next_node_idx_o     = idx_q;
    assign next_node_counter_o = cnt_q;
    assign load_err_o          = load_err_q;
    assign req_ready_o         = req_ready_q;

endmodule

// File: tb/tb_graph_adj_responder.sv
// Scoreboard bench for graph_adj_responder: expected beats queued at request time,
// compared as the responder hands them over.
module tb_graph_adj_responder;

    typedef struct packed {
        logic [9:0] idx;
        logic [4:0] cnt;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic [1:0]  load_sel;
    logic [11:0] load_addr;
    logic [16:0] load_data;
    logic        load_err;
    logic        part_sel;
    logic        hdr_req;
    logic        rd_req;
    logic [9:0]  node_idx;
    logic        req_ready;
    logic        edge_valid;
    logic        edge_ready;
    logic [9:0]  next_node_idx;
    logic [4:0]  next_node_counter;

    beat_t sb[$];
    int    n_total = 0;
    int    n_pass  = 0;

    always #5 clk = ~clk;

    graph_adj_responder #(
        .PARAM_NODE_IDX_WIDTH (10),
        .PARAM_COUNTER_WIDTH  (5),
        .PARAM_EDGE_ADDR_WIDTH(12),
        .PARAM_NUM_NODES      (1000)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .load_en_i          (load_en),
        .load_sel_i         (load_sel),
        .load_addr_i        (load_addr),
        .load_data_i        (load_data),
        .load_err_o         (load_err),
        .part_sel_i         (part_sel),
        .hdr_req_i          (hdr_req),
        .rd_req_i           (rd_req),
        .node_idx_i         (node_idx),
        .req_ready_o        (req_ready),
        .edge_valid_o       (edge_valid),
        .edge_ready_i       (edge_ready),
        .next_node_idx_o    (next_node_idx),
        .next_node_counter_o(next_node_counter)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [1:0] sel, input int addr, input logic [16:0] data);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = 12'(addr);
        load_data = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic push(input int idx, input int cnt);
        beat_t b;
        b.idx = 10'(idx);
        b.cnt = 5'(cnt);
        sb.push_back(b);
    endtask

    task automatic hdr(input logic p);
        part_sel = p;
        hdr_req  = 1'b1;
        tick();
        hdr_req  = 1'b0;
    endtask

    task automatic rd(input int n);
        node_idx = 10'(n);
        rd_req   = 1'b1;
        tick();
        rd_req   = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && req_ready) break;
            tick();
        end
        check({tag, "_done"}, 32'(sb.size() == 0 && req_ready), 32'd1);
        tick();
        check({tag, "_valid_low"}, 32'(edge_valid), 32'd0);
    endtask

    // Consumer side: every accepted beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && edge_valid && edge_ready) begin
            if (sb.size() == 0) begin
                check("beat_unexpected", 32'(next_node_idx), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_idx", 32'(next_node_idx), 32'(e.idx));
                check("beat_cnt", 32'(next_node_counter), 32'(e.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; load_en = 1'b0; load_sel = '0; load_addr = '0; load_data = '0;
        part_sel = 1'b0; hdr_req = 1'b0; rd_req = 1'b0; node_idx = '0; edge_ready = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(edge_valid), 32'd0);
        check("rst_idx", 32'(next_node_idx), 32'd0);
        check("rst_cnt", 32'(next_node_counter), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;

        // Graph contents
        load(2'd2, 0, 17'd3);
        load(2'd2, 1, 17'd7);
        load(2'd2, 2, 17'd9);
        load(2'd2, 3, 17'd12);
        load(2'd0, 5, {12'd40, 5'd3});
        load(2'd1, 40, 17'd8);
        load(2'd1, 41, 17'd11);
        load(2'd1, 42, 17'd2);
        load(2'd0, 6, {12'd100, 5'd0});
        load(2'd0, 7, {12'd4094, 5'd3});
        load(2'd1, 4094, 17'd21);
        load(2'd1, 4095, 17'd22);
        load(2'd1, 0, 17'd23);
        check("load_err_idle", 32'(load_err), 32'd0);

        // Part 1 header
        push(3, 2); push(12, 1);
        hdr(1'b0);
        check("hdr1_lat", 32'(edge_valid), 32'd1);
        check("hdr1_busy", 32'(req_ready), 32'd0);
        wait_idle("hdr1");

        // Part 2 header
        push(3, 4); push(7, 3); push(9, 2); push(12, 1);
        hdr(1'b1);
        wait_idle("hdr2");

        // hdr_req wins over a simultaneous rd_req
        push(3, 2); push(12, 1);
        part_sel = 1'b0; node_idx = 10'd5; hdr_req = 1'b1; rd_req = 1'b1;
        tick();
        hdr_req = 1'b0; rd_req = 1'b0;
        wait_idle("prio");

        // Node 5 with a two-cycle stall on the second beat
        push(8, 3); push(11, 2); push(2, 1);
        rd(5);
`ifndef ADJ_PREFETCH_EN
        check("rd_lat_gap", 32'(edge_valid), 32'd0);
        tick();
`endif
        check("rd_lat", 32'(edge_valid), 32'd1);
        tick();
        edge_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("stall_valid", 32'(edge_valid), 32'd1);
            check("stall_idx", 32'(next_node_idx), 32'd11);
            check("stall_cnt", 32'(next_node_counter), 32'd2);
        end
        edge_ready = 1'b1;
        wait_idle("node5");

        // Zero-degree node and out-of-range node
        push(0, 0);
        rd(6);
        wait_idle("deg0");
        push(0, 0);
        rd(1023);
        wait_idle("oor");

        // Edge address wrap
        push(21, 3); push(22, 2); push(23, 1);
        rd(7);
        wait_idle("wrap");

        // Load during stream is dropped; reset mid-stream
        edge_ready = 1'b0;
        rd(5);
`ifndef ADJ_PREFETCH_EN
        tick();
`endif
        check("t6_valid", 32'(edge_valid), 32'd1);
        load(2'd0, 5, {12'd0, 5'd1});
        check("t6_load_err", 32'(load_err), 32'd1);
        rst = 1'b1;
        tick();
        check("t6_rst_valid", 32'(edge_valid), 32'd0);
        check("t6_rst_err", 32'(load_err), 32'd0);
        check("t6_rst_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        edge_ready = 1'b1;
        push(8, 3); push(11, 2); push(2, 1);
        rd(5);
        wait_idle("retain");

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
